// File: rtl/flit_pkg.sv
// Shared constants and encodings for the flit assembler.
package flit_pkg;

    localparam int FLIT_W = 16;
    localparam int N_BODY = 4;
    localparam int IDX_W  = $clog2(N_BODY);

    typedef enum logic [1:0] {
        FT_HEAD = 2'b00,
        FT_BODY = 2'b01,
        FT_TAIL = 2'b10,
        FT_RSVD = 2'b11
    } flit_type_e;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        TAIL,
        ISSUE,
        WAIT_DONE
    } asm_state_e;

endpackage

// File: rtl/flit_watchdog.sv
// Loadable down-counter: clear reloads LOAD_VALUE, en counts down,
// expire flags the enabled cycle that would take the count to zero.
module flit_watchdog #(
    parameter int LOAD_VALUE = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = $clog2(LOAD_VALUE + 1);

    logic [CNT_W-1:0] cnt;

    // Reload on clear, otherwise count down while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= CNT_W'(LOAD_VALUE);
        end else if (clear) begin
            cnt <= CNT_W'(LOAD_VALUE);
        end else if (en && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expire = en && (cnt == CNT_W'(1));

endmodule

// File: rtl/flit_assembler.sv
// Collects head + 4 body + tail flits, presents them in parallel to the
// packet decoder, pulses o_en and waits for i_dec_done. Malformed packets
// and stray flits are dropped and counted.
// Define FLIT_ASM_TIMEOUT_EN to build the inter-flit watchdog
// (TIMEOUT_CYCLES idle cycles in COLLECT/TAIL abort the packet).
module flit_assembler
    import flit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flit_valid,
    input  logic [1:0]        i_flit_type,
    input  logic [FLIT_W-1:0] i_flit,
    output logic              o_flit_ready,
    input  logic              i_dec_done,
    output logic [FLIT_W-1:0] o_head_flit,
    output logic [FLIT_W-1:0] o_body_flit_1,
    output logic [FLIT_W-1:0] o_body_flit_2,
    output logic [FLIT_W-1:0] o_body_flit_3,
    output logic [FLIT_W-1:0] o_body_flit_4,
    output logic [FLIT_W-1:0] o_tail_flit,
    output logic              o_en,
    output logic              o_err,
    output logic [7:0]        o_pkt_count,
    output logic [7:0]        o_drop_count
);

    asm_state_e        state;
    flit_type_e        ftype;
    logic [IDX_W-1:0]  body_idx;
    logic [FLIT_W-1:0] body_q [N_BODY];
    logic              accept;
    logic              flit_err;
    logic              wd_expire;

    assign ftype        = flit_type_e'(i_flit_type);
    assign o_flit_ready = (state == IDLE) || (state == COLLECT) || (state == TAIL);
    assign accept       = i_flit_valid && o_flit_ready;

    assign o_body_flit_1 = body_q[0];
    assign o_body_flit_2 = body_q[1];
    assign o_body_flit_3 = body_q[2];
    assign o_body_flit_4 = body_q[3];

`ifdef FLIT_ASM_TIMEOUT_EN
    logic wd_active;
    assign wd_active = (state == COLLECT) || (state == TAIL);

    flit_watchdog #(
        .LOAD_VALUE(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept || !wd_active),
        .en     (wd_active && !accept),
        .expire (wd_expire)
    );
`else
    assign wd_expire = 1'b0;
`endif

    // Framing violation: an accepted flit of the wrong type for the state, or a watchdog expiry.
    always_comb begin
        // NOTE: default assignment first so no path leaves flit_err unassigned (no latch).
        flit_err = 1'b0;
        if (accept) begin
            case (state)
                IDLE:    flit_err = (ftype != FT_HEAD);
                COLLECT: flit_err = (ftype != FT_BODY);
                TAIL:    flit_err = (ftype != FT_TAIL);
                default: flit_err = 1'b0;
            endcase
        end
        if (wd_expire) flit_err = 1'b1;
    end

    // Framing FSM, flit registers, pulses and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            body_idx     <= '0;
            // NOTE: the flit storage drives outputs that must read 0 after reset, so it is reset too.
            o_head_flit  <= '0;
            o_tail_flit  <= '0;
            for (int i = 0; i < N_BODY; i++) body_q[i] <= '0;
            o_en         <= 1'b0;
            o_err        <= 1'b0;
            o_pkt_count  <= '0;
            o_drop_count <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            o_en  <= 1'b0;
            o_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept && ftype == FT_HEAD) begin
                        o_head_flit <= i_flit;
                        body_idx    <= '0;
                        state       <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        case (ftype)
                            FT_BODY: begin
                                body_q[body_idx] <= i_flit;
                                body_idx         <= body_idx + IDX_W'(1);
                                if (body_idx == IDX_W'(N_BODY - 1)) state <= TAIL;
                            end
                            FT_HEAD: begin
                                o_head_flit <= i_flit;
                                body_idx    <= '0;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
                TAIL: begin
                    if (accept) begin
                        case (ftype)
                            FT_TAIL: begin
                                o_tail_flit <= i_flit;
                                o_en        <= 1'b1;
                                o_pkt_count <= o_pkt_count + 8'd1;
                                state       <= ISSUE;
                            end
                            FT_HEAD: begin
                                o_head_flit <= i_flit;
                                body_idx    <= '0;
                                state       <= COLLECT;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
                ISSUE:     state <= WAIT_DONE;
                WAIT_DONE: if (i_dec_done) state <= IDLE;
                default:   state <= IDLE;
            endcase

            if (wd_expire) state <= IDLE;

            if (flit_err) begin
                o_err <= 1'b1;
                if (o_drop_count != 8'hFF) o_drop_count <= o_drop_count + 8'd1;
            end
        end
    end

endmodule
